// File: rtl/fnb_pkg.sv
// fnb_pkg: shared types and elaboration helpers for the FNB layer plumbing.
// Used by fnb_a_serializer (optional shadow buffer: FNB_A_SERIALIZER_SHADOW_EN).
package fnb_pkg;

   // One-hot serializer states; any other encoding is illegal.
   typedef enum logic [1:0] {
      SM_IDLE   = 2'b01,
      SM_STREAM = 2'b10
   } fnb_ser_sm_t;

   // Bits needed to hold a count 0..value-1, never less than one bit.
   function automatic int log2up(input int value);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if (int'(32'd1 << i) < value) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

   // Number of output beats per input vector.
   function automatic int fnb_beats(input int n, input int p);
      return n / p;
   endfunction

endpackage

// File: rtl/dvr_if.sv
// dvr_if: data / valid / ready handshake bundle used between FNB blocks.
// A transfer happens on a rising clock edge where valid and rdy are both high.
interface dvr_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              rdy;

   modport master (output data, output valid, input rdy);
   modport slave  (input data, input valid, output rdy);
endinterface

// File: rtl/fnb_a_serializer.sv
// fnb_a_serializer: turns a full N-activation vector into N/P beats of P
// activations for the next layer. Both sides honour backpressure.
// Optional shadow buffer (macro FNB_A_SERIALIZER_SHADOW_EN) accepts the next
// vector while the current one streams, removing the idle cycle between vectors.
module fnb_a_serializer
   import fnb_pkg::*;
#(
   parameter int A_WIDTH        = 18,
   parameter int NUM_OF_NUERONS = 4,
   parameter int PIPE_SIZE      = 1
) (
   input  logic  clk,
   input  logic  rst_n,
   dvr_if.slave  a_mat,
   dvr_if.master a_st,
   output logic  a_st_last,
   output logic  busy,
   output logic  irq
);

   localparam int BEATS   = fnb_beats(NUM_OF_NUERONS, PIPE_SIZE);
   localparam int CNT_W   = log2up(BEATS);
   localparam int VEC_W   = A_WIDTH * NUM_OF_NUERONS;
   localparam int SLICE_W = A_WIDTH * PIPE_SIZE;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

   if ((NUM_OF_NUERONS % PIPE_SIZE) != 32'sd0) begin : g_cfg_err
      $error("fnb_a_serializer: NUM_OF_NUERONS (%0d) is not a multiple of PIPE_SIZE (%0d)",
             NUM_OF_NUERONS, PIPE_SIZE);
   end

   fnb_ser_sm_t        state_q, state_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [VEC_W-1:0]   main_q, main_d;
   logic [SLICE_W-1:0] st_data_q, st_data_d;
   logic               irq_q, irq_d;
   logic               mat_rdy_q, mat_rdy_d;
   logic               st_valid_q, st_valid_d;
   logic               st_last_q, st_last_d;
   logic               busy_q, busy_d;
   logic               beat_take_s;
   logic               last_beat_s;

`ifdef FNB_A_SERIALIZER_SHADOW_EN
   logic [VEC_W-1:0]   shadow_q, shadow_d;
   logic               shadow_full_q, shadow_full_d;
   logic               vec_take_s;

   assign vec_take_s = a_mat.valid & mat_rdy_q;
`endif

   assign beat_take_s = st_valid_q & a_st.rdy;
   assign last_beat_s = (beat_cnt_q == CNT_LAST);

   // Next state, vector loads and the next values of every registered output.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      main_d     = main_q;
      irq_d      = irq_q;
`ifdef FNB_A_SERIALIZER_SHADOW_EN
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
`endif
      case (state_q)
         SM_IDLE: begin
            if (a_mat.valid) begin
               main_d     = a_mat.data;
               beat_cnt_d = CNT_ZERO;
               state_d    = SM_STREAM;
            end else begin
               state_d    = SM_IDLE;
            end
         end
         SM_STREAM: begin
`ifdef FNB_A_SERIALIZER_SHADOW_EN
            // Park an early vector; overridden below if it goes straight to main.
            if (vec_take_s) begin
               shadow_d      = a_mat.data;
               shadow_full_d = 1'b1;
            end else begin
               shadow_full_d = shadow_full_q;
            end
`endif
            if (beat_take_s) begin
               if (last_beat_s) begin
                  beat_cnt_d = CNT_ZERO;
`ifdef FNB_A_SERIALIZER_SHADOW_EN
                  if (shadow_full_q) begin
                     main_d        = shadow_q;
                     shadow_full_d = 1'b0;
                     state_d       = SM_STREAM;
                  end else if (a_mat.valid) begin
                     main_d        = a_mat.data;
                     shadow_full_d = 1'b0;
                     state_d       = SM_STREAM;
                  end else begin
                     state_d       = SM_IDLE;
                  end
`else
                  state_d    = SM_IDLE;
`endif
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_ONE;
               end
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         default: begin
            irq_d      = 1'b1;
            state_d    = SM_IDLE;
            beat_cnt_d = CNT_ZERO;
`ifdef FNB_A_SERIALIZER_SHADOW_EN
            shadow_full_d = 1'b0;
`endif
         end
      endcase

      st_valid_d = (state_d == SM_STREAM);
      st_last_d  = (state_d == SM_STREAM) && (beat_cnt_d == CNT_LAST);
`ifdef FNB_A_SERIALIZER_SHADOW_EN
      mat_rdy_d  = ~shadow_full_d;
      busy_d     = st_valid_d | shadow_full_d;
`else
      mat_rdy_d  = (state_d == SM_IDLE);
      busy_d     = st_valid_d;
`endif
      st_data_d  = main_d[int'(beat_cnt_d) * SLICE_W +: SLICE_W];
   end

   // Control state and handshake outputs; reset drops any vector in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SM_IDLE;
         beat_cnt_q    <= CNT_ZERO;
         irq_q         <= 1'b0;
         mat_rdy_q     <= 1'b1;
         st_valid_q    <= 1'b0;
         st_last_q     <= 1'b0;
         busy_q        <= 1'b0;
`ifdef FNB_A_SERIALIZER_SHADOW_EN
         shadow_full_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         irq_q         <= irq_d;
         mat_rdy_q     <= mat_rdy_d;
         st_valid_q    <= st_valid_d;
         st_last_q     <= st_last_d;
         busy_q        <= busy_d;
`ifdef FNB_A_SERIALIZER_SHADOW_EN
         shadow_full_q <= shadow_full_d;
`endif
      end
   end

   // Vector storage and the presented beat; qualified by valid, so not reset.
   always_ff @(posedge clk) begin
      main_q    <= main_d;
      st_data_q <= st_data_d;
`ifdef FNB_A_SERIALIZER_SHADOW_EN
      shadow_q  <= shadow_d;
`endif
   end

   assign a_mat.rdy  = mat_rdy_q;
   assign a_st.valid = st_valid_q;
   assign a_st.data  = st_data_q;
   assign a_st_last  = st_last_q;
   assign busy       = busy_q;
   assign irq        = irq_q;

endmodule
